// File: rtl/red_seq_unit.sv
// Multi-cycle lane reduction unit: sums sign-extended LANE_W lanes of A and B, one lane pair per cycle.
// Optional RED_LEGACY_ADD_EN enables a single-edge plain A+B path selected by mode=1.
module red_seq_unit #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Sum,
    output logic [1:0]        dbg_state
);
    localparam int N     = DATA_W / LANE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = LANE_W + 1 + $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1
    } state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [DATA_W-1:0]         sum_q, sum_d;
    logic [DATA_W-1:0]         a_q, a_d;
    logic [DATA_W-1:0]         b_q, b_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic signed [LANE_W-1:0]  a_lane;
    logic signed [LANE_W-1:0]  b_lane;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      legacy_go;
    logic [DATA_W-1:0]         legacy_sum;

`ifdef RED_LEGACY_ADD_EN
    assign legacy_go  = mode;
    assign legacy_sum = A + B;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign legacy_go   = 1'b0;
    assign legacy_sum  = '0;
`endif

    // Lane idx_q of each latched operand, sign-extended into the accumulator width.
    assign a_lane   = a_q[idx_q*LANE_W +: LANE_W];
    assign b_lane   = b_q[idx_q*LANE_W +: LANE_W];
    assign acc_next = acc_q + ACC_W'(a_lane) + ACC_W'(b_lane);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legacy_go) begin
                        sum_d  = legacy_sum;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                        busy_d  = 1'b1;
                        a_d     = A;
                        b_d     = B;
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            S_ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = DATA_W'(acc_next);
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Sum       = sum_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_red_seq_unit.sv
// Directed bench for red_seq_unit with default parameters (16-bit operands, 4-bit lanes).
// Define RED_LEGACY_ADD_EN for both files to exercise the plain-add path.
module tb_red_seq_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    red_seq_unit #(.DATA_W(16), .LANE_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sum of the eight sign-extended nibbles of a and b.
    function automatic logic [15:0] red_model(input logic [15:0] a, input logic [15:0] b);
        int s;
        logic signed [3:0] la;
        logic signed [3:0] lb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            la = a[i*4 +: 4];
            lb = b[i*4 +: 4];
            s  = s + int'(la) + int'(lb);
        end
        return s[15:0];
    endfunction

    // Present a request for one edge, then scramble the operands.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m);
        start = 1'b1;
        A     = a;
        B     = b;
        mode  = m;
        step();
        start = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
        mode  = 1'b0;
    endtask

    // Cycle 1 is the cycle after the accepting edge; stops at done or a 16-cycle bound.
    task automatic wait_done(output int cyc, output int nb);
        cyc = 1;
        nb  = 0;
        while (done !== 1'b1 && cyc < 16) begin
            if (busy === 1'b1) nb++;
            step();
            cyc++;
        end
    endtask

    task automatic run_red(input logic [15:0] a, input logic [15:0] b, input logic m,
                           input logic [15:0] exp_sum, input int exp_cyc, input int exp_nb,
                           input string tag);
        int cyc;
        int nb;
        issue(a, b, m);
        wait_done(cyc, nb);
        check({tag, "_lat"}, cyc, exp_cyc);
        check({tag, "_busy_cycles"}, nb, exp_nb);
        check({tag, "_sum"}, Sum, exp_sum);
        step();
        check({tag, "_done_fall"}, done, 1'b0);
        check({tag, "_sum_hold"}, Sum, exp_sum);
    endtask

    initial begin
        int cyc;
        int nb;
        int dc;
        int ok_ops;
        logic [15:0] seen;
        logic [15:0] ra;
        logic [15:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", Sum, 16'h0000);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        step();

        run_red(16'h1234, 16'h1111, 1'b0, 16'h000E, 5, 4, "pos");
        run_red(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFF8, 5, 4, "neg1");
        run_red(16'h8888, 16'h8888, 1'b0, 16'hFFC0, 5, 4, "most_neg");
        run_red(16'h7777, 16'h7777, 1'b0, 16'h0038, 5, 4, "most_pos");

        // Start pulsed during ACCUM must be ignored.
        issue(16'h1234, 16'h1111, 1'b0);
        check("coll_busy", busy, 1'b1);
        step();
        start = 1'b1;
        A     = 16'hFFFF;
        B     = 16'hFFFF;
        step();
        start = 1'b0;
        dc    = 0;
        seen  = '0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                dc++;
                seen = Sum;
            end
            step();
        end
        check("coll_done_count", dc, 1);
        check("coll_sum", seen, 16'h000E);

        // Start in the done cycle is accepted.
        issue(16'h7777, 16'h7777, 1'b0);
        wait_done(cyc, nb);
        check("b2b_first_sum", Sum, 16'h0038);
        start = 1'b1;
        A     = 16'h8888;
        B     = 16'h8888;
        step();
        start = 1'b0;
        A     = '0;
        B     = '0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        wait_done(cyc, nb);
        check("b2b_lat", cyc, 5);
        check("b2b_sum", Sum, 16'hFFC0);
        step();

        // Reset during the second ACCUM cycle aborts the operation.
        issue(16'h1234, 16'h1111, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", Sum, 16'h0000);
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dc++;
            step();
        end
        check("abort_no_done", dc, 0);
        run_red(16'h1234, 16'h1111, 1'b0, 16'h000E, 5, 4, "post_abort");

`ifdef RED_LEGACY_ADD_EN
        run_red(16'hFFFF, 16'h0002, 1'b1, 16'h0001, 1, 0, "legacy");
`else
        run_red(16'hFFFF, 16'h0002, 1'b1, 16'hFFFE, 5, 4, "legacy_off");
`endif

        ok_ops = 0;
        for (int i = 0; i < 200; i++) begin
            int bad_before;
            bad_before = bad;
            ra = 16'($urandom);
            rb = 16'($urandom);
            issue(ra, rb, 1'b0);
            wait_done(cyc, nb);
            check("rand_lat", cyc, 5);
            check("rand_sum", Sum, red_model(ra, rb));
            if (bad != bad_before) begin
                $display("random sweep stopped at a=%h b=%h", ra, rb);
                break;
            end
            ok_ops++;
            step();
        end
        $display("random sweep: %0d operations matched", ok_ops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
